// File: rtl/vector_instr_sequencer_if.sv
// Program-load and issue bundle for the vector instruction sequencer.
// master = software/driver side, slave = sequencer side.
interface vector_instr_sequencer_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [12:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          pause;
  logic [12:0]   instruction_set;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          wr_reject;

  modport master (
    output prog_we, prog_addr, prog_data,
    output prog_len, start, pause,
    input  instruction_set, instr_valid,
    input  pc, busy, done, wr_reject
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  prog_len, start, pause,
    output instruction_set, instr_valid,
    output pc, busy, done, wr_reject
  );
endinterface

// File: rtl/vector_instr_sequencer.sv
// Replays a loaded instruction program into the vector processor,
// inserting per-opcode settle gaps between issues.
module vector_instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int MEM_GAP = 0,
  parameter int ALU_GAP = 2
) (
  input  logic clk,
  input  logic reset,
  vector_instr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0]  MG  = 8'(MEM_GAP);
  localparam logic [7:0]  AG  = 8'(ALU_GAP);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state;
  state_t        state_nx;
  logic [12:0]   mem [DEPTH];
  logic [AW:0]   len;
  logic [AW-1:0] pc;
  logic [7:0]    cnt;
  logic [7:0]    gap;
  logic [12:0]   instr;
  logic          wr_rej;
  logic          last;
  logic          adv;
  logic          go;

  assign gap  = instr[12] ? AG : MG;
  assign last = ({1'b0, pc} == (len - ONE));
  assign go   = (state == S_IDLE) && bus.start;
  assign adv  = ((state == S_ISSUE) && (gap == 8'd0))
             || ((state == S_WAIT) && !bus.pause
                 && (cnt == 8'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (go)
          state_nx = (bus.prog_len != '0) ? S_FETCH
                                          : S_DONE;
      end
      S_FETCH: begin
        if (!bus.pause) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (gap != 8'd0) state_nx = S_WAIT;
        else             state_nx = last ? S_DONE : S_FETCH;
      end
      S_WAIT: begin
        if (adv) state_nx = last ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = 1'b1;
    bus.instr_valid = 1'b0;
    bus.done        = 1'b0;
    unique case (state)
      S_IDLE:  bus.busy        = 1'b0;
      S_ISSUE: bus.instr_valid = 1'b1;
      S_DONE:  bus.done        = 1'b1;
      default: ;
    endcase
  end

  // Buffer content survives reset; only IDLE writes land.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state == S_IDLE))
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len    <= '0;
      pc     <= '0;
      cnt    <= '0;
      instr  <= '0;
      wr_rej <= 1'b0;
    end else begin
      wr_rej <= bus.prog_we && (state != S_IDLE);
      if (go && (bus.prog_len != '0)) begin
        len <= bus.prog_len;
        pc  <= '0;
      end else if (adv && !last) begin
        pc  <= pc + AW'(1);
      end
      // The synchronous read lands directly in the issue register.
      if ((state == S_FETCH) && !bus.pause)
        instr <= mem[pc];
      if (state == S_ISSUE)
        cnt <= gap;
      else if ((state == S_WAIT) && !bus.pause)
        cnt <= cnt - 8'd1;
    end
  end

  assign bus.instruction_set = instr;
  assign bus.pc              = pc;
  assign bus.wr_reject       = wr_rej;

endmodule

// File: tb/tb_vector_instr_sequencer.sv
// Directed bench for vector_instr_sequencer: issue timing, gaps,
// pause, rejected writes, zero-length and full-length runs, reset.
module tb_vector_instr_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [12:0] prog_m [16];

  vector_instr_sequencer_if #(.AW(4)) bus ();

  vector_instr_sequencer #(
    .DEPTH(16), .AW(4), .MEM_GAP(0), .ALU_GAP(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [12:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(a);
    bus.prog_data = d;
    cyc();
    bus.prog_we = 1'b0;
    prog_m[a]   = d;
  endtask

  // Starts a run at the current cycle (offset 0) and checks
  // every cycle through offset dn+1 against the masks.
  task automatic run(input string tag, input int len,
                     input logic [63:0] vmask, input int dn,
                     input logic [63:0] pmask,
                     input int we_off, input int st_off);
    int k = 0;
    bus.prog_len = 5'(len);
    bus.start    = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int off = 1; off <= dn + 1; off++) begin
      check($sformatf("%s@%0d valid", tag, off),
            32'(bus.instr_valid), 32'(vmask[off]));
      if (vmask[off]) begin
        check($sformatf("%s@%0d instr", tag, off),
              32'(bus.instruction_set), 32'(prog_m[k]));
        check($sformatf("%s@%0d pc", tag, off),
              32'(bus.pc), 32'(k));
        k++;
      end
      check($sformatf("%s@%0d done", tag, off),
            32'(bus.done), 32'(off == dn));
      check($sformatf("%s@%0d busy", tag, off),
            32'(bus.busy), 32'(off <= dn));
      check($sformatf("%s@%0d wrrej", tag, off),
            32'(bus.wr_reject),
            32'(we_off >= 0 && off == we_off + 1));
      bus.pause     = pmask[off];
      bus.prog_we   = (off == we_off);
      bus.prog_addr = 4'd1;
      bus.prog_data = 13'h1FFF;
      bus.start     = (off == st_off);
      bus.prog_len  = 5'd1;
      cyc();
    end
    bus.pause   = 1'b0;
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, " instr"}, 32'(bus.instruction_set), 0);
    check({tag, " valid"}, 32'(bus.instr_valid), 0);
    check({tag, " pc"}, 32'(bus.pc), 0);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " done"}, 32'(bus.done), 0);
    check({tag, " wrrej"}, 32'(bus.wr_reject), 0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    foreach (prog_m[i]) prog_m[i] = '0;
    cyc();
    cyc();
    chk_reset_vals("por");
    reset = 1'b1;
    cyc();

    wr(0, 13'h0002);
    wr(1, 13'h1000);
    wr(2, 13'h1A00);
    run("basic", 3, 64'h114, 11, 64'h0, -1, -1);
    check("basic pc_end", 32'(bus.pc), 2);

    run("len0", 0, 64'h0, 1, 64'h0, -1, -1);

    run("busywr", 3, 64'h114, 11, 64'h0, 1, 3);

    run("pause", 3, 64'h2014, 16, 64'h3E4, -1, -1);

    for (int i = 1; i < 16; i++)
      wr(i, 13'h0800 | 13'(i));
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = 13'h0855;
    prog_m[0]     = 13'h0855;
    run("full", 16, 64'h1_5555_5554, 33, 64'h0, -1, -1);
    check("full pc_end", 32'(bus.pc), 15);

    wr(0, 13'h0002);
    wr(1, 13'h1000);
    wr(2, 13'h1A00);
    bus.prog_len = 5'd3;
    bus.start    = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (4) cyc();
    check("midrun busy", 32'(bus.busy), 1);
    check("midrun pc", 32'(bus.pc), 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    cyc();
    check("inrst done", 32'(bus.done), 0);
    check("inrst busy", 32'(bus.busy), 0);
    reset = 1'b1;
    cyc();
    run("rerun", 3, 64'h114, 11, 64'h0, -1, -1);
    check("rerun pc_end", 32'(bus.pc), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
